// File: rtl/operand_bypass_unit_pkg.sv
// ============================================================================
// operand_bypass_unit_pkg: shared bypass-state and FSM encodings | rev 1.0
// ============================================================================
`default_nettype none

package operand_bypass_unit_pkg;

  localparam int BYPASS_STATE_WIDTH = 2;

  localparam logic [BYPASS_STATE_WIDTH-1:0] BYPASS_STATE_MISS = 2'd0;
  localparam logic [BYPASS_STATE_WIDTH-1:0] BYPASS_STATE_HIT  = 2'd1;
  localparam logic [BYPASS_STATE_WIDTH-1:0] BYPASS_STATE_WAIT = 2'd2;

  localparam int DEFAULT_DATA_SIZE = 32;
  localparam int DEFAULT_TAG_W     = 3;

  typedef enum logic [0:0] {
    FSM_IDLE = 1'b0,
    FSM_WAIT = 1'b1
  } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/operand_bypass_unit_slot.sv
// ============================================================================
// operand_bypass_unit_slot: per-operand pending flag, tag, value and tag match | rev 1.0
// ============================================================================
`default_nettype none

module operand_bypass_unit_slot
  import operand_bypass_unit_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int TAG_W     = DEFAULT_TAG_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          load,
  input  logic                          force_ready,
  input  logic [DATA_SIZE-1:0]          force_value,
  input  logic [BYPASS_STATE_WIDTH-1:0] rob_state,
  input  logic [DATA_SIZE-1:0]          rob_value,
  input  logic [DATA_SIZE-1:0]          rf_value,
  input  logic [TAG_W-1:0]              rob_tag,
  input  logic                          wb_valid,
  input  logic [TAG_W-1:0]              wb_tag,
  input  logic [DATA_SIZE-1:0]          wb_value,
  output logic [DATA_SIZE-1:0]          value,
  output logic                          pending,
  output logic                          ready_now,
  output logic                          wake
);

  logic                 r_pending;
  logic [TAG_W-1:0]     r_tag;
  logic [DATA_SIZE-1:0] r_value;

  logic [TAG_W-1:0]     w_cmp_tag;
  logic                 w_tag_match;
  logic                 w_ready;
  logic [DATA_SIZE-1:0] w_value;

  // One comparator serves both the parked tag and the same-cycle wakeup in ID.
  assign w_cmp_tag   = r_pending ? r_tag : rob_tag;
  assign w_tag_match = wb_valid && (wb_tag == w_cmp_tag);

  always_comb begin
    w_ready = 1'b1;
    w_value = '0;
    if (force_ready) begin
      w_value = force_value;
    end else begin
      case (rob_state)
        BYPASS_STATE_HIT:  w_value = rob_value;
        BYPASS_STATE_WAIT: begin
          if (w_tag_match) w_value = wb_value;
          else             w_ready = 1'b0;
        end
        default:           w_value = rf_value;
      endcase
    end
  end

  assign wake = r_pending && w_tag_match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
      r_tag     <= '0;
      r_value   <= '0;
    end else if (flush) begin
      r_pending <= 1'b0;
    end else if (load) begin
      r_pending <= !w_ready;
      r_tag     <= rob_tag;
      if (w_ready) r_value <= w_value;
    end else if (wake) begin
      r_pending <= 1'b0;
      r_value   <= wb_value;
    end
  end

  assign value     = r_value;
  assign pending   = r_pending;
  assign ready_now = w_ready;

endmodule

`default_nettype wire

// File: rtl/operand_bypass_unit.sv
// ============================================================================
// operand_bypass_unit: stateful ID operand forwarder with ROB-tag wakeup | rev 1.0
// ============================================================================
`default_nettype none

module operand_bypass_unit
  import operand_bypass_unit_pkg::*;
#(
  parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
  parameter int REG_W       = 5,
  parameter int NUM_OPS     = 2,
  parameter int TAG_W       = DEFAULT_TAG_W,
  parameter int NUM_SPECIAL = 8,
  parameter int STALL_W     = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   id_valid,
  input  logic                                   is_mov,
  input  logic [REG_W-1:0]                       spec_sel,
  input  logic [NUM_OPS-1:0]                     op_used,
  input  logic [NUM_OPS*REG_W-1:0]               op_addr,
  input  logic [NUM_OPS*DATA_SIZE-1:0]           rf_value,
  input  logic [NUM_OPS*BYPASS_STATE_WIDTH-1:0]  rob_state,
  input  logic [NUM_OPS*DATA_SIZE-1:0]           rob_value,
  input  logic [NUM_OPS*TAG_W-1:0]               rob_tag,
  input  logic                                   wb_valid,
  input  logic [TAG_W-1:0]                       wb_tag,
  input  logic [DATA_SIZE-1:0]                   wb_value,
  input  logic [NUM_SPECIAL*DATA_SIZE-1:0]       special_regs,
  output logic [NUM_OPS*DATA_SIZE-1:0]           op_value,
  output logic                                   out_valid,
  output logic                                   stop,
  output logic [STALL_W-1:0]                     stall_cycles
);

  fsm_state_t r_state;
  fsm_state_t w_state_next;

  logic                         r_out_valid;
  logic [STALL_W-1:0]           r_stall_cycles;

  logic [NUM_OPS-1:0]           w_force_ready;
  logic [NUM_OPS*DATA_SIZE-1:0] w_force_value;
  logic [NUM_OPS-1:0]           w_ready_now;
  logic [NUM_OPS-1:0]           w_pending;
  logic [NUM_OPS-1:0]           w_wake;
  logic [DATA_SIZE-1:0]         w_special;
  logic                         w_load;
  logic                         w_remaining;
  logic                         w_done;
  logic                         w_stop;

  // Out-of-range selectors fall through every compare and read as zero.
  always_comb begin
    w_special = '0;
    for (int k = 0; k < NUM_SPECIAL; k++) begin
      if (spec_sel == REG_W'(k)) w_special = special_regs[k*DATA_SIZE +: DATA_SIZE];
    end
  end

  always_comb begin
    w_force_ready = '0;
    w_force_value = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (!op_used[i]) begin
        w_force_ready[i] = 1'b1;
      end else if (is_mov && (i == 0)) begin
        w_force_ready[i]                        = 1'b1;
        w_force_value[i*DATA_SIZE +: DATA_SIZE] = w_special;
      end else if (op_addr[i*REG_W +: REG_W] == '0) begin
        w_force_ready[i] = 1'b1;
      end
    end
  end

  assign w_load = (r_state == FSM_IDLE) && id_valid && !flush;

  generate
    for (genvar g = 0; g < NUM_OPS; g++) begin : g_slot
      operand_bypass_unit_slot #(
        .DATA_SIZE (DATA_SIZE),
        .TAG_W     (TAG_W)
      ) u_operand_slot (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .load        (w_load),
        .force_ready (w_force_ready[g]),
        .force_value (w_force_value[g*DATA_SIZE +: DATA_SIZE]),
        .rob_state   (rob_state[g*BYPASS_STATE_WIDTH +: BYPASS_STATE_WIDTH]),
        .rob_value   (rob_value[g*DATA_SIZE +: DATA_SIZE]),
        .rf_value    (rf_value[g*DATA_SIZE +: DATA_SIZE]),
        .rob_tag     (rob_tag[g*TAG_W +: TAG_W]),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .wb_value    (wb_value),
        .value       (op_value[g*DATA_SIZE +: DATA_SIZE]),
        .pending     (w_pending[g]),
        .ready_now   (w_ready_now[g]),
        .wake        (w_wake[g])
      );
    end
  endgenerate

  assign w_remaining = |(w_pending & ~w_wake);

  always_comb begin
    w_state_next = r_state;
    w_stop       = 1'b0;
    w_done       = 1'b0;
    if (flush) begin
      w_state_next = FSM_IDLE;
    end else begin
      case (r_state)
        FSM_IDLE: begin
          if (id_valid) begin
            if (&w_ready_now) begin
              w_done = 1'b1;
            end else begin
              w_state_next = FSM_WAIT;
              w_stop       = 1'b1;
            end
          end
        end
        FSM_WAIT: begin
          if (w_remaining) begin
            w_stop = 1'b1;
          end else begin
            w_done       = 1'b1;
            w_state_next = FSM_IDLE;
          end
        end
        default: w_state_next = FSM_IDLE;
      endcase
    end
  end

  // Gated so every output reads zero while reset is held.
  assign stop = reset && w_stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= FSM_IDLE;
      r_out_valid    <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_done;
      if (stop && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign out_valid    = r_out_valid;
  assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire
